// File: rtl/fetch_pc_stage.sv
// rtl/fetch_pc_stage.sv - Instruction-fetch stage: program counter, IF/ID register, redirect, fault and halt
//
// Purpose:
//   Owns the program counter that addresses instruction memory and captures
//   the returned instruction word into the IF/ID pipeline register. Handles
//   stall, flush on redirect, misaligned-target fault and the end-of-memory halt.
//
// Ports:
//   clk             in   1   rising-edge clock
//   rst             in   1   asynchronous active-high reset
//   stall           in   1   hold PC and IF/ID this cycle
//   redirect        in   1   taken branch/jump from downstream
//   redirect_target in  32   byte address of redirect target
//   Instr_In        in  32   instruction word at PC_Out (combinational memory)
//   PC_Out          out 32   current fetch address
//   ifid_valid      out  1   IF/ID holds a real instruction
//   ifid_pc         out 32   PC of the instruction in IF/ID
//   ifid_instr      out 32   instruction word in IF/ID
//   halted          out  1   fetch stopped (end of memory or fault)
//   fault           out  1   sticky misaligned-redirect indication

module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 44,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] Instr_In,
    output logic [31:0] PC_Out,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        halted,
    output logic        fault
);

    // Last address whose word lies entirely inside instruction memory.
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_halted;
    logic        r_fault;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_ifid_valid_nxt;
    logic [31:0] w_ifid_pc_nxt;
    logic [31:0] w_ifid_instr_nxt;
    logic        w_halted_nxt;
    logic        w_fault_nxt;

    logic        w_target_aligned;
    logic        w_at_last_pc;

    assign w_target_aligned = (redirect_target[1:0] == 2'b00);
    assign w_at_last_pc     = (r_pc >= LAST_PC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_instr <= NOP_INSTR;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_halted     <= w_halted_nxt;
            r_fault      <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_valid_nxt = r_ifid_valid;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_halted_nxt     = r_halted;
        w_fault_nxt      = r_fault;

        case (r_state)
            // Memory output is not trusted on the first cycle after reset,
            // so nothing is captured and all control inputs are ignored.
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end

            S_RUN: begin
                if (redirect) begin
                    // Any redirect squashes the instruction that was being
                    // fetched down the wrong path.
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_pc_nxt    = 32'h0000_0000;
                    w_ifid_instr_nxt = NOP_INSTR;
                    if (w_target_aligned) begin
                        w_pc_nxt = redirect_target;
                    end else begin
                        w_fault_nxt  = 1'b1;
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = S_HALT;
                    end
                end else if (!stall) begin
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_instr_nxt = Instr_In;
                    w_ifid_valid_nxt = 1'b1;
                    // The last word is still delivered; only the PC stops.
                    if (w_at_last_pc) begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = S_HALT;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
            end

            // Clearing valid on every HALT edge is equivalent to clearing it
            // on the first one, so the final instruction shows for one cycle.
            S_HALT: begin
                w_ifid_valid_nxt = 1'b0;
                w_ifid_instr_nxt = NOP_INSTR;
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign PC_Out     = r_pc;
    assign ifid_valid = r_ifid_valid;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;
    assign halted     = r_halted;
    assign fault      = r_fault;

endmodule
